// File: rtl/gate_resp_checker_if.sv
// gate_resp_checker_if: stimulus/response and status bundle for the gate response checker
interface gate_resp_checker_if #(parameter int WIDTH = 1, parameter int CNT_W = 16);
  logic start, valid, busy, done, pass, covered;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b, y;
  logic [CNT_W-1:0] sample_cnt, err_cnt, first_err_idx;
  modport master(output start, op, valid, a, b, y,
                 input busy, done, pass, covered, sample_cnt, err_cnt, first_err_idx);
  modport slave(input start, op, valid, a, b, y,
                output busy, done, pass, covered, sample_cnt, err_cnt, first_err_idx);
endinterface

// File: rtl/gate_resp_checker.sv
// gate_resp_checker: latency-aligned checker of a gate DUT with error counting and input coverage
module gate_resp_checker #(
  parameter int WIDTH = 1,
  parameter int LAT = 0,
  parameter int NUM_SAMPLES = 16,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  gate_resp_checker_if.slave bus
);
  localparam int IW = $clog2(NUM_SAMPLES + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op_q;
  logic [IW-1:0] iss;
  logic [4*WIDTH-1:0] cov, cov_set;
  logic [WIDTH-1:0] exp_c, out_e;
  logic out_v, pend, load, acc, cmp, cov_ok;
  logic [CNT_W-1:0] smp, err, first;
  assign load = bus.start && (state == IDLE || state == DONE);
  assign acc = state == RUN && bus.valid;
  assign cmp = out_v && (state == RUN || state == DRAIN);
  always_comb begin
    case (op_q)
      3'd0: exp_c = bus.a & bus.b;
      3'd1: exp_c = bus.a | bus.b;
      3'd2: exp_c = bus.a ^ bus.b;
      3'd3: exp_c = ~(bus.a ^ bus.b);
      3'd4: exp_c = ~(bus.a & bus.b);
      3'd5: exp_c = ~(bus.a | bus.b);
      3'd6: exp_c = ~bus.a;
      default: exp_c = bus.a;
    endcase
  end
  generate
    if (LAT == 0) begin : g_comb
      assign out_v = acc;
      assign out_e = exp_c;
      assign pend = 1'b0;
    end else begin : g_pipe
      logic [LAT-1:0] pv;
      logic [LAT-1:0][WIDTH-1:0] pe;
      always_ff @(posedge clk) begin
        if (rst || load) begin
          pv <= '0;
          pe <= '0;
        end else begin
          pv <= LAT'({pv, acc});
          pe <= (LAT*WIDTH)'({pe, exp_c});
        end
      end
      assign out_v = pv[LAT-1];
      assign out_e = pe[LAT-1];
      // entries still queued behind the one being compared this cycle
      assign pend = |LAT'(pv << 1);
    end
  endgenerate
  always_comb begin
    cov_set = '0;
    for (int i = 0; i < WIDTH; i++) cov_set[4*i +: 4] = 4'(acc) << {bus.a[i], bus.b[i]};
  end
  always_comb begin
    cov_ok = 1'b1;
    for (int i = 0; i < WIDTH; i++)
      cov_ok = cov_ok & ((op_q[2:1] == 2'b11) ? (|cov[4*i +: 2] && |cov[4*i+2 +: 2]) : &cov[4*i +: 4]);
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = bus.start ? RUN : state;
      RUN: state_nx = (acc && iss == IW'(NUM_SAMPLES - 1)) ? DRAIN : RUN;
      default: state_nx = pend ? DRAIN : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q <= '0;
      iss <= '0;
      cov <= '0;
      smp <= '0;
      err <= '0;
      first <= '1;
    end else begin
      state <= state_nx;
      if (load) begin
        op_q <= bus.op;
        iss <= '0;
        cov <= '0;
        smp <= '0;
        err <= '0;
        first <= '1;
      end else begin
        if (acc) iss <= iss + 1'b1;
        cov <= cov | cov_set;
        if (cmp) begin
          smp <= smp + 1'b1;
          if (bus.y != out_e) begin
            if (err != '1) err <= err + 1'b1;
            if (first == '1) first <= smp;
          end
        end
      end
    end
  end
  assign bus.busy = state == RUN || state == DRAIN;
  assign bus.done = state == DONE;
  assign bus.covered = cov_ok;
  assign bus.pass = state == DONE && err == '0 && cov_ok;
  assign bus.sample_cnt = smp;
  assign bus.err_cnt = err;
  assign bus.first_err_idx = first;
endmodule

// File: tb/tb_gate_resp_checker.sv
// tb_gate_resp_checker: directed-vector bench for gate_resp_checker across latency and counter widths
module tb_gate_resp_checker;
  logic clk = 1'b0, rst = 1'b1, slow;
  logic [1:0] d1, d2;
  int n_chk = 0, n_err = 0;
  logic [4:0] seq [7] = '{5'b1_00_00, 5'b0_00_00, 5'b1_10_01, 5'b0_00_00, 5'b1_01_10, 5'b0_00_00, 5'b1_11_11};
  gate_resp_checker_if #(.WIDTH(1), .CNT_W(16)) i0();
  gate_resp_checker_if #(.WIDTH(2), .CNT_W(16)) i1();
  gate_resp_checker_if #(.WIDTH(1), .CNT_W(2)) i2();
  gate_resp_checker #(.WIDTH(1), .LAT(0), .NUM_SAMPLES(4), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(i0));
  gate_resp_checker #(.WIDTH(2), .LAT(2), .NUM_SAMPLES(4), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(i1));
  gate_resp_checker #(.WIDTH(1), .LAT(0), .NUM_SAMPLES(6), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .bus(i2));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    d1 <= i1.a & i1.b;
    d2 <= d1;
  end
  assign i1.y = slow ? d2 : d1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic v0(input logic v, input logic a, input logic b, input logic y);
    i0.valid = v;
    i0.a = a;
    i0.b = b;
    i0.y = y;
    tick();
  endtask
  task automatic start0(input logic [2:0] op);
    i0.op = op;
    i0.valid = 1'b0;
    i0.start = 1'b1;
    tick();
    i0.start = 1'b0;
  endtask
  task automatic run1();
    i1.op = 3'd0;
    i1.start = 1'b1;
    tick();
    i1.start = 1'b0;
    for (int t = 0; t < 7; t++) begin
      {i1.valid, i1.a, i1.b} = seq[t];
      tick();
    end
    {i1.valid, i1.a, i1.b} = '0;
    tick();
    chk("lat2_drain_busy", i1.done, 0);
    tick();
  endtask
  initial begin
    {i0.start, i0.valid, i0.a, i0.b, i0.y, i0.op} = '0;
    {i1.start, i1.valid, i1.a, i1.b, i1.op} = '0;
    {i2.start, i2.valid, i2.a, i2.b, i2.y, i2.op} = '0;
    slow = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", i0.busy, 0);
    chk("rst_done", i0.done, 0);
    chk("rst_pass", i0.pass, 0);
    chk("rst_covered", i0.covered, 0);
    chk("rst_sample", i0.sample_cnt, 0);
    chk("rst_err", i0.err_cnt, 0);
    chk("rst_first", i0.first_err_idx, 32'hFFFF);
    chk("rst_first_w2", i2.first_err_idx, 3);
    start0(3'd3);
    chk("xnor_busy", i0.busy, 1);
    for (int k = 0; k < 4; k++) v0(1'b1, k[1], k[0], ~(k[1] ^ k[0]));
    chk("xnor_drain_done", i0.done, 0);
    chk("xnor_drain_busy", i0.busy, 1);
    v0(1'b1, 1'b0, 1'b0, 1'b0);
    i0.valid = 1'b0;
    chk("xnor_done", i0.done, 1);
    chk("xnor_sample", i0.sample_cnt, 4);
    chk("xnor_err", i0.err_cnt, 0);
    chk("xnor_covered", i0.covered, 1);
    chk("xnor_pass", i0.pass, 1);
    chk("xnor_first", i0.first_err_idx, 32'hFFFF);
    start0(3'd3);
    chk("restart_done", i0.done, 0);
    chk("restart_sample", i0.sample_cnt, 0);
    for (int k = 0; k < 4; k++) v0(1'b1, k[1], k[0], 1'b0);
    v0(1'b0, 1'b0, 1'b0, 1'b0);
    chk("stuck_done", i0.done, 1);
    chk("stuck_err", i0.err_cnt, 2);
    chk("stuck_first", i0.first_err_idx, 0);
    chk("stuck_pass", i0.pass, 0);
    chk("stuck_covered", i0.covered, 1);
    start0(3'd3);
    v0(1'b1, 1'b0, 1'b0, 1'b0);
    v0(1'b1, 1'b0, 1'b1, 1'b0);
    chk("mid_sample", i0.sample_cnt, 2);
    chk("mid_err", i0.err_cnt, 1);
    chk("mid_first", i0.first_err_idx, 0);
    rst = 1'b1;
    i0.valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_busy", i0.busy, 0);
    chk("midrst_sample", i0.sample_cnt, 0);
    chk("midrst_err", i0.err_cnt, 0);
    chk("midrst_first", i0.first_err_idx, 32'hFFFF);
    {i0.valid, i0.a, i0.b, i0.y} = 4'b1_0_0_0;
    i0.start = 1'b1;
    tick();
    i0.start = 1'b0;
    chk("collide_sample", i0.sample_cnt, 0);
    chk("collide_err", i0.err_cnt, 0);
    chk("collide_busy", i0.busy, 1);
    for (int k = 0; k < 4; k++) v0(1'b1, k[1], k[0], ~(k[1] ^ k[0]));
    v0(1'b0, 1'b0, 1'b0, 1'b0);
    chk("collide_done", i0.done, 1);
    chk("collide_err_end", i0.err_cnt, 0);
    chk("collide_sample_end", i0.sample_cnt, 4);
    start0(3'd2);
    v0(1'b1, 1'b0, 1'b0, 1'b0);
    v0(1'b1, 1'b0, 1'b1, 1'b1);
    v0(1'b1, 1'b0, 1'b1, 1'b1);
    v0(1'b1, 1'b1, 1'b0, 1'b1);
    v0(1'b0, 1'b0, 1'b0, 1'b0);
    chk("xor_done", i0.done, 1);
    chk("xor_err", i0.err_cnt, 0);
    chk("xor_covered", i0.covered, 0);
    chk("xor_pass", i0.pass, 0);
    start0(3'd6);
    v0(1'b1, 1'b0, 1'b0, 1'b1);
    v0(1'b1, 1'b1, 1'b0, 1'b0);
    v0(1'b1, 1'b0, 1'b0, 1'b1);
    v0(1'b1, 1'b1, 1'b0, 1'b0);
    v0(1'b0, 1'b0, 1'b0, 1'b0);
    chk("not_err", i0.err_cnt, 0);
    chk("not_covered", i0.covered, 1);
    chk("not_pass", i0.pass, 1);
    run1();
    chk("lat2_done", i1.done, 1);
    chk("lat2_sample", i1.sample_cnt, 4);
    chk("lat2_err", i1.err_cnt, 0);
    chk("lat2_covered", i1.covered, 1);
    chk("lat2_pass", i1.pass, 1);
    slow = 1'b0;
    run1();
    chk("lat1_done", i1.done, 1);
    chk("lat1_err", i1.err_cnt, 1);
    chk("lat1_first", i1.first_err_idx, 3);
    chk("lat1_pass", i1.pass, 0);
    i2.op = 3'd0;
    i2.start = 1'b1;
    tick();
    i2.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      {i2.valid, i2.a, i2.b} = {1'b1, k[0], k[1]};
      i2.y = ~(k[0] & k[1]);
      tick();
      if (k == 2) chk("sat_err_mid", i2.err_cnt, 3);
    end
    i2.valid = 1'b0;
    tick();
    chk("sat_done", i2.done, 1);
    chk("sat_err", i2.err_cnt, 3);
    chk("sat_sample_wrap", i2.sample_cnt, 2);
    chk("sat_first", i2.first_err_idx, 0);
    chk("sat_pass", i2.pass, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
